qupls4_checkpoint_release: RTL

Tracks every allocated branch checkpoint in allocation order. Retires checkpoints in order once their branch resolves, and flushes younger checkpoints immediately on a mispredict. Sits directly upstream of the checkpoint allocator and is the sole producer of its `chkpts_to_free` bitmap. Consumes allocation reports from rename and resolution reports from the branch units.

---
 rtl/Qupls4_pkg.sv | 20 ++
 rtl/Qupls4_chkpt_age_mask.sv | 21 ++
 rtl/qupls4_checkpoint_release.sv | 136 +++++++++++++
 3 files changed

// File: rtl/Qupls4_pkg.sv
// Shared checkpoint types for the Qupls4 rename/checkpoint path.
package Qupls4_pkg;

  localparam int NCHECK = 16;
  localparam int CHKW   = $clog2(NCHECK);

  typedef logic [CHKW-1:0] checkpt_ndx_t;

  typedef struct packed {
    logic         valid;
    logic         resolved;
    checkpt_ndx_t ndx;
  } chkpt_rel_slot_t;

  function automatic logic [CHKW:0] popcnt(input logic [NCHECK-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NCHECK; i++) popcnt = popcnt + {{CHKW{1'b0}}, v[i]};
  endfunction

endpackage

// File: rtl/Qupls4_chkpt_age_mask.sv
// Marks every queue slot that is younger than flush_slot, with age measured from head.
module Qupls4_chkpt_age_mask
  import Qupls4_pkg::*;
(
  input  checkpt_ndx_t       head,
  input  checkpt_ndx_t       flush_slot,
  output logic [NCHECK-1:0]  younger
);

  checkpt_ndx_t flush_age;

  assign flush_age = flush_slot - head;

  always_comb begin
    younger = '0;
    for (int s = 0; s < NCHECK; s++) begin
      younger[s] = (checkpt_ndx_t'(s) - head) > flush_age;
    end
  end

endmodule

// File: rtl/qupls4_checkpoint_release.sv
// In-order tracker of allocated branch checkpoints: retires resolved ones from the head,
// flushes younger ones on a mispredict, and reports freed indices to the allocator.
module qupls4_checkpoint_release
  import Qupls4_pkg::*;
#(
  parameter int NCHECK = Qupls4_pkg::NCHECK,
  parameter int NRES   = 2
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_v,
  input  checkpt_ndx_t             alloc_ndx,
  input  logic [NRES-1:0]          res_v,
  input  checkpt_ndx_t [NRES-1:0]  res_ndx,
  input  logic [NRES-1:0]          res_mispred,
  output logic [NCHECK-1:0]        chkpts_to_free,
  output logic                     restore_v,
  output checkpt_ndx_t             restore_ndx,
  output logic [$clog2(NCHECK):0]  count,
  output logic                     err
);

  typedef logic [$clog2(NCHECK):0] cnt_t;

  // Inputs are valid-only qualifiers with no back-pressure: every asserted alloc_v/res_v
  // is consumed on the edge that samples it; outputs are registered single-cycle pulses.
  chkpt_rel_slot_t            slots     [NCHECK];
  chkpt_rel_slot_t            slots_nxt [NCHECK];
  checkpt_ndx_t               head, tail, head_nxt, tail_nxt, h1;
  checkpt_ndx_t               flush_slot, flush_ndx;
  checkpt_ndx_t [NRES-1:0]    hit_slot;
  logic [NRES-1:0]            hit, mp;
  logic [NCHECK-1:0]          valid_vec, young1, young_f, flush_mask, free_nxt;
  logic                       sel1, flush_v, pop0, pop1, alloc_bad, alloc_ok, err_nxt;
  cnt_t                       npop, count_nxt;

  always_comb begin
    valid_vec = '0;
    for (int p = 0; p < NRES; p++) begin
      hit[p]      = 1'b0;
      hit_slot[p] = '0;
    end
    for (int s = 0; s < NCHECK; s++) begin
      valid_vec[s] = slots[s].valid;
      for (int p = 0; p < NRES; p++) begin
        if (slots[s].valid && slots[s].ndx == res_ndx[p]) begin
          hit[p]      = 1'b1;
          hit_slot[p] = checkpt_ndx_t'(s);
        end
      end
    end
  end

  // Port 1 wins only when port 0's slot lies younger than port 1's.
  Qupls4_chkpt_age_mask u_sel_age (
    .head       (head),
    .flush_slot (hit_slot[1]),
    .younger    (young1)
  );

  Qupls4_chkpt_age_mask u_flush_age (
    .head       (head),
    .flush_slot (flush_slot),
    .younger    (young_f)
  );

  assign mp         = res_v & res_mispred & hit;
  assign sel1       = mp[1] && (!mp[0] || young1[hit_slot[0]]);
  assign flush_v    = |mp;
  assign flush_slot = sel1 ? hit_slot[1] : hit_slot[0];
  assign flush_ndx  = sel1 ? res_ndx[1] : res_ndx[0];
  assign flush_mask = flush_v ? (young_f & valid_vec) : '0;

  // Retire looks at the resolved bits registered before this edge.
  assign h1    = head + 1'b1;
  assign pop0  = slots[head].valid && slots[head].resolved;
  assign pop1  = pop0 && slots[h1].valid && slots[h1].resolved && !flush_mask[h1];
  assign npop  = cnt_t'(pop0) + cnt_t'(pop1);

  assign alloc_bad = alloc_v && (alloc_ndx == '0 || count == cnt_t'(NCHECK - 1));
  assign alloc_ok  = alloc_v && !alloc_bad && !flush_v;
  assign err_nxt   = err || alloc_bad || |(res_v & ~hit);

  always_comb begin
    slots_nxt = slots;
    free_nxt  = '0;
    for (int p = 0; p < NRES; p++) begin
      if (res_v[p] && !res_mispred[p] && hit[p]) slots_nxt[hit_slot[p]].resolved = 1'b1;
    end
    if (flush_v) slots_nxt[flush_slot].resolved = 1'b1;
    for (int s = 0; s < NCHECK; s++) begin
      if (flush_mask[s]) begin
        slots_nxt[s].valid      = 1'b0;
        free_nxt[slots[s].ndx]  = 1'b1;
      end
    end
    if (pop0) begin
      slots_nxt[head].valid      = 1'b0;
      free_nxt[slots[head].ndx]  = 1'b1;
    end
    if (pop1) begin
      slots_nxt[h1].valid        = 1'b0;
      free_nxt[slots[h1].ndx]    = 1'b1;
    end
    // An alloc that collides with a flush is handed straight back so it cannot leak.
    if (alloc_v && flush_v) free_nxt[alloc_ndx] = 1'b1;
    if (alloc_ok) slots_nxt[tail] = '{valid: 1'b1, resolved: 1'b0, ndx: alloc_ndx};
    free_nxt[0] = 1'b0;
    head_nxt  = head + checkpt_ndx_t'(npop);
    tail_nxt  = flush_v ? flush_slot + 1'b1 : (alloc_ok ? tail + 1'b1 : tail);
    count_nxt = count - npop - popcnt(flush_mask) + cnt_t'(alloc_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NCHECK; s++) slots[s] <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      chkpts_to_free <= '0;
      restore_v      <= 1'b0;
      restore_ndx    <= '0;
      err            <= 1'b0;
    end else begin
      slots          <= slots_nxt;
      head           <= head_nxt;
      tail           <= tail_nxt;
      count          <= count_nxt;
      chkpts_to_free <= free_nxt;
      restore_v      <= flush_v;
      if (flush_v) restore_ndx <= flush_ndx;
      err            <= err_nxt;
    end
  end

endmodule
